// File: rtl/hms_clock_ctrl.sv
// Hour/minute/second timekeeping core with a button-driven set mode.
// Binary counters, single-field edit in SET, day rollover pulse.
module hms_clock_ctrl #(
    parameter int HOUR_MAX = 23
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_tick,
    input  logic       i_mode_btn,
    input  logic       i_pos_btn,
    input  logic       i_inc_btn,
    output logic [5:0] o_sec,
    output logic [5:0] o_min,
    output logic [5:0] o_hour,
    output logic       o_mode,
    output logic [1:0] o_pos,
    output logic [5:0] o_six_dp,
    output logic       o_day_pulse
);

    typedef enum logic {
        CLOCK = 1'b0,
        SET   = 1'b1
    } state_t;

    localparam logic [5:0] LP_HMAX = 6'(HOUR_MAX);

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_mode_d;
    logic       r_pos_d;
    logic       r_inc_d;
    logic [5:0] r_sec;
    logic [5:0] r_min;
    logic [5:0] r_hour;
    logic [1:0] r_pos;
    logic       r_day;
    logic [5:0] w_sec_nxt;
    logic [5:0] w_min_nxt;
    logic [5:0] w_hour_nxt;
    logic [1:0] w_pos_nxt;
    logic       w_day_nxt;
    logic       w_mode_ev;
    logic       w_pos_ev;
    logic       w_inc_ev;
    logic       w_sec_wrap;
    logic       w_min_wrap;
    logic       w_hour_wrap;

    // A mode event masks the edit buttons in the same cycle.
    assign w_mode_ev   = i_mode_btn & ~r_mode_d;
    assign w_pos_ev    = i_pos_btn & ~r_pos_d & ~w_mode_ev;
    assign w_inc_ev    = i_inc_btn & ~r_inc_d & ~w_mode_ev;
    assign w_sec_wrap  = r_sec >= 6'd59;
    assign w_min_wrap  = r_min >= 6'd59;
    assign w_hour_wrap = r_hour >= LP_HMAX;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= CLOCK;
            r_mode_d <= 1'b0;
            r_pos_d  <= 1'b0;
            r_inc_d  <= 1'b0;
            r_sec    <= '0;
            r_min    <= '0;
            r_hour   <= '0;
            r_pos    <= '0;
            r_day    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_mode_d <= i_mode_btn;
            r_pos_d  <= i_pos_btn;
            r_inc_d  <= i_inc_btn;
            r_sec    <= w_sec_nxt;
            r_min    <= w_min_nxt;
            r_hour   <= w_hour_nxt;
            r_pos    <= w_pos_nxt;
            r_day    <= w_day_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sec_nxt   = r_sec;
        w_min_nxt   = r_min;
        w_hour_nxt  = r_hour;
        w_pos_nxt   = r_pos;
        w_day_nxt   = 1'b0;
        unique case (r_state)
            CLOCK: begin
                // Old state governs counting, so a tick with the entry edge counts.
                if (i_tick) begin
                    w_sec_nxt = w_sec_wrap ? 6'd0 : r_sec + 6'd1;
                    if (w_sec_wrap) begin
                        w_min_nxt = w_min_wrap ? 6'd0 : r_min + 6'd1;
                        if (w_min_wrap) begin
                            w_hour_nxt = w_hour_wrap ? 6'd0 : r_hour + 6'd1;
                            w_day_nxt  = w_hour_wrap;
                        end
                    end
                end
                if (w_mode_ev) begin
                    w_state_nxt = SET;
                    w_pos_nxt   = 2'd0;
                end
            end
            SET: begin
                if (w_mode_ev) begin
                    w_state_nxt = CLOCK;
                end
                if (w_inc_ev) begin
                    case (r_pos)
                        2'd0:    w_sec_nxt  = w_sec_wrap ? 6'd0 : r_sec + 6'd1;
                        2'd1:    w_min_nxt  = w_min_wrap ? 6'd0 : r_min + 6'd1;
                        2'd2:    w_hour_nxt = w_hour_wrap ? 6'd0 : r_hour + 6'd1;
                        default: w_sec_nxt  = r_sec;
                    endcase
                end
                if (w_pos_ev) begin
                    w_pos_nxt = (r_pos >= 2'd2) ? 2'd0 : r_pos + 2'd1;
                end
            end
        endcase
    end

    always_comb begin
        o_six_dp = 6'b000000;
        if (r_state == SET) begin
            case (r_pos)
                2'd0:    o_six_dp = 6'b000011;
                2'd1:    o_six_dp = 6'b001100;
                2'd2:    o_six_dp = 6'b110000;
                default: o_six_dp = 6'b000000;
            endcase
        end
    end

    assign o_sec       = r_sec;
    assign o_min       = r_min;
    assign o_hour      = r_hour;
    assign o_mode      = (r_state == SET);
    assign o_pos       = r_pos;
    assign o_day_pulse = r_day;

endmodule

// File: tb/tb_hms_clock_ctrl.sv
// Bench for hms_clock_ctrl: 24 h and 12-slot builds side by side,
// checked every cycle against a seconds-of-day model.
module tb_hms_clock_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       mb = 1'b0;
    logic       pb = 1'b0;
    logic       ib = 1'b0;
    logic [5:0] o_sec [2];
    logic [5:0] o_min [2];
    logic [5:0] o_hour [2];
    logic       o_mode [2];
    logic [1:0] o_pos [2];
    logic [5:0] o_dp [2];
    logic       o_day [2];

    int nvec = 0;
    int nmis = 0;

    int tm [2];
    int ps [2];
    bit md [2];
    bit dy [2];
    int hmx [2] = '{23, 11};
    bit pm, pp, pi;

    always #5 clk = ~clk;

    hms_clock_ctrl #(.HOUR_MAX(23)) u_d24 (
        .clk(clk), .rst(rst), .i_tick(tick),
        .i_mode_btn(mb), .i_pos_btn(pb), .i_inc_btn(ib),
        .o_sec(o_sec[0]), .o_min(o_min[0]), .o_hour(o_hour[0]),
        .o_mode(o_mode[0]), .o_pos(o_pos[0]), .o_six_dp(o_dp[0]),
        .o_day_pulse(o_day[0])
    );

    hms_clock_ctrl #(.HOUR_MAX(11)) u_d12 (
        .clk(clk), .rst(rst), .i_tick(tick),
        .i_mode_btn(mb), .i_pos_btn(pb), .i_inc_btn(ib),
        .o_sec(o_sec[1]), .o_min(o_min[1]), .o_hour(o_hour[1]),
        .o_mode(o_mode[1]), .o_pos(o_pos[1]), .o_six_dp(o_dp[1]),
        .o_day_pulse(o_day[1])
    );

    task automatic m_reset();
        for (int k = 0; k < 2; k++) begin
            tm[k] = 0; ps[k] = 0; md[k] = 0; dy[k] = 0;
        end
        pm = 0; pp = 0; pi = 0;
    endtask

    task automatic m_step();
        bit mev, pev, iev;
        int h, mi, s;
        mev = mb && !pm;
        pev = pb && !pp && !mev;
        iev = ib && !pi && !mev;
        for (int k = 0; k < 2; k++) begin
            dy[k] = 0;
            if (!md[k]) begin
                if (tick) begin
                    tm[k] = (tm[k] + 1) % ((hmx[k] + 1) * 3600);
                    dy[k] = (tm[k] == 0);
                end
                if (mev) begin
                    md[k] = 1; ps[k] = 0;
                end
            end else if (mev) begin
                md[k] = 0;
            end else begin
                h = tm[k] / 3600; mi = (tm[k] / 60) % 60; s = tm[k] % 60;
                if (iev) begin
                    if (ps[k] == 0) s = (s + 1) % 60;
                    else if (ps[k] == 1) mi = (mi + 1) % 60;
                    else h = (h + 1) % (hmx[k] + 1);
                end
                tm[k] = h * 3600 + mi * 60 + s;
                if (pev) ps[k] = (ps[k] + 1) % 3;
            end
        end
        pm = mb; pp = pb; pi = ib;
    endtask

    task automatic compare();
        logic [27:0] got, exp;
        logic [5:0] dp;
        for (int k = 0; k < 2; k++) begin
            dp = md[k] ? (6'b000011 << (2 * ps[k])) : 6'b000000;
            exp = {6'(tm[k] % 60), 6'((tm[k] / 60) % 60), 6'(tm[k] / 3600),
                   md[k], 2'(ps[k]), dp, dy[k]};
            got = {o_sec[k], o_min[k], o_hour[k], o_mode[k], o_pos[k],
                   o_dp[k], o_day[k]};
            nvec++;
            if (got !== exp) begin
                nmis++;
                $display("FAIL cycle dut%0d t=%0t got %h want %h", k, $time, got, exp);
            end
        end
    endtask

    task automatic chk(input string nm, input int got, input int exp);
        nvec++;
        if (got != exp) begin
            nmis++;
            $display("FAIL %s got %0d want %0d", nm, got, exp);
        end
    endtask

    task automatic cyc(input bit t, input bit m, input bit p, input bit i);
        @(negedge clk);
        tick = t; mb = m; pb = p; ib = i;
        @(posedge clk);
        if (rst) m_reset();
        else m_step();
        #1 compare();
    endtask

    task automatic press_mode();
        cyc(0, 1, 0, 0); cyc(0, 0, 0, 0);
    endtask

    task automatic press_pos();
        cyc(0, 0, 1, 0); cyc(0, 0, 0, 0);
    endtask

    task automatic press_inc(input int n);
        for (int j = 0; j < n; j++) begin
            cyc(0, 0, 0, 1); cyc(0, 0, 0, 0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
        @(negedge clk);
        rst = 0;
    endtask

    initial begin
        m_reset();
        cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
        @(negedge clk);
        rst = 0;
        chk("rst_sec", o_sec[0], 0);
        chk("rst_mode", o_mode[0], 0);

        for (int j = 0; j < 59; j++) begin
            cyc(1, 0, 0, 0); cyc(0, 0, 0, 0);
        end
        chk("sec59", o_sec[0], 59);
        cyc(1, 0, 0, 0);
        chk("wrap_sec", o_sec[0], 0);
        chk("wrap_min", o_min[0], 1);

        press_mode();
        chk("set_mode", o_mode[0], 1);
        chk("set_dp", o_dp[0], 6'b000011);
        press_inc(59);
        press_pos();
        press_inc(58);
        press_pos();
        chk("pos2", o_pos[0], 2);
        chk("dp_hour", o_dp[0], 6'b110000);
        press_inc(23);
        chk("hour23", o_hour[0], 23);
        chk("hour11_12h", o_hour[1], 11);
        press_inc(1);
        chk("hour_wrap", o_hour[0], 0);
        press_inc(23);
        chk("hour_back", o_hour[0], 23);
        chk("min_kept", o_min[0], 59);
        for (int j = 0; j < 5; j++) cyc(1, 0, 0, 0);
        chk("set_frozen", o_sec[0], 59);
        press_pos();
        chk("pos_cycle", o_pos[0], 0);
        press_mode();
        cyc(1, 0, 0, 0);
        chk("day_24", o_day[0], 1);
        chk("day_12", o_day[1], 1);
        chk("roll_hour", o_hour[0], 0);
        chk("roll_12", o_hour[1], 0);
        cyc(0, 0, 0, 0);
        chk("day_once", o_day[0], 0);

        for (int j = 0; j < 5; j++) cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 0);
        chk("tick_entry_sec", o_sec[0], 6);
        chk("tick_entry_mode", o_mode[0], 1);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 1);
        chk("pos_inc_sec", o_sec[0], 7);
        chk("pos_inc_pos", o_pos[0], 1);
        cyc(0, 0, 0, 0);
        cyc(1, 1, 0, 1);
        chk("mode_inc_mode", o_mode[0], 0);
        chk("mode_inc_min", o_min[0], 0);
        chk("exit_tick_drop", o_sec[0], 7);
        cyc(0, 0, 0, 0);
        press_mode();
        for (int j = 0; j < 1000; j++) cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        chk("held_inc", o_sec[0], 8);
        press_mode();

        for (int j = 0; j < 3000; j++) begin
            cyc(($urandom % 3) == 0,
                ($urandom % 20) == 0 ? !mb : mb,
                ($urandom % 6) == 0 ? !pb : pb,
                ($urandom % 3) == 0 ? !ib : ib);
        end

        do_reset();
        press_mode();
        press_inc(56);
        press_pos();
        press_inc(34);
        press_pos();
        press_inc(12);
        chk("pre_h", o_hour[0], 12);
        chk("pre_m", o_min[0], 34);
        chk("pre_s", o_sec[0], 56);
        @(negedge clk);
        #2 rst = 1;
        #1;
        chk("async_sec", o_sec[0], 0);
        chk("async_min", o_min[0], 0);
        chk("async_hour", o_hour[0], 0);
        chk("async_mode", o_mode[0], 0);
        chk("async_dp", o_dp[0], 0);
        m_reset();
        cyc(0, 0, 0, 1);
        @(negedge clk);
        rst = 0;
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/hms_clock_ctrl.md
# hms_clock_ctrl

Hour/minute/second timekeeping core with a button-driven set mode. It sits directly upstream of the two-digit separators and FND decoders that feed the six-digit display multiplexer. It consumes a one-cycle 1 Hz enable pulse from an NCO-style divider and three debounced push-button levels. It produces binary seconds, minutes and hours (each 0..59 / 0..HOUR_MAX), plus a six-bit decimal-point vector that marks the field currently being edited.

## Interface
- HOUR_MAX, 23: last hour value before wrap to 0 (23 gives a 24 h clock; 11 gives 0..11).
- clk  input  1  system clock (50 MHz in the top level).
- rst  input  1  reset; asynchronous, active-high.
- i_tick  input  1  one-clk-wide 1 Hz enable pulse.
- i_mode_btn  input  1  debounced level; a rising edge toggles CLOCK/SET.
- i_pos_btn  input  1  debounced level; a rising edge advances the edit field (SET only).
- i_inc_btn  input  1  debounced level; a rising edge increments the edit field (SET only).
- o_sec  output  6  seconds, binary 0..59.
- o_min  output  6  minutes, binary 0..59.
- o_hour  output  6  hours, binary 0..HOUR_MAX.
- o_mode  output  1  0 = CLOCK, 1 = SET.
- o_pos  output  2  edit field: 0 = SEC, 1 = MIN, 2 = HOUR (3 never occurs).
- o_six_dp  output  6  DP enables: bits[1:0] = sec digits, [3:2] = min, [5:4] = hour.
- o_day_pulse  output  1  one-cycle pulse on the HOUR_MAX:59:59 -> 0:00:00 rollover.

## Operation
- Edge detect: each button has a registered copy (_d). An event is btn=1 and btn_d=0. The _d registers update every clk. Holding a button gives exactly one event.
- Mode FSM, two states:
  - CLOCK -> SET on a mode event; o_pos is forced to SEC on entry.
  - SET -> CLOCK on a mode event; o_pos is held.
- CLOCK state:
  - i_tick increments sec.
  - sec 59 -> 0 carries into min; min 59 -> 0 carries into hour; hour HOUR_MAX -> 0.
  - o_day_pulse is high for the cycle after the full rollover edge, i.e. registered together with the counters.
  - pos and inc events are ignored.
- SET state:
  - i_tick is ignored; time is frozen.
  - A pos event cycles SEC -> MIN -> HOUR -> SEC.
  - An inc event adds 1 to the selected field, modulo its own limit (59 or HOUR_MAX), with no carry into other fields and no o_day_pulse.
  - Entering SET does not reset sec.
- Priority within one clk:
  - A mode event suppresses pos and inc events in that cycle.
  - A pos event and an inc event together: the inc applies to the old field, then the field advances.
  - An i_tick coinciding with a CLOCK -> SET mode event is still counted (old state governs the counting).
  - An i_tick coinciding with a SET -> CLOCK mode event is dropped.
- o_six_dp: in SET, both bits of the selected field are 1 and all others 0. In CLOCK, all bits are 0. The output is combinational from o_mode/o_pos.
- Width rules:
  - Counters are compared with >= for wrap, so any out-of-range value wraps to 0 on the next increment.
  - HOUR_MAX must be in 1..59.

## Timing
- Reset (asserted asynchronously, held any duration):
  - o_sec = o_min = o_hour = 0.
  - o_mode = 0, o_pos = 0, o_six_dp = 0, o_day_pulse = 0.
  - All button _d registers = 0. A button held high through reset release therefore produces one event on the first clk edge after release.
- Latency: 1 clk from the sampling edge to the registered outputs, for ticks and button events. o_six_dp follows o_mode/o_pos in the same cycle.
- Reset mid-operation clears everything, including SET state, immediately (no clk needed).
- Reset has no restriction on duration or alignment relative to i_tick.

## Test plan
- Reset then 59 ticks: o_sec = 59. The 60th tick gives o_sec = 0 and o_min = 1 one clk after the tick edge.
- Preload to 23:59:59 via SET (hour 23, min 59, sec 59), return to CLOCK, then one tick: all fields 0, and o_day_pulse is high for exactly one clk.
- Mode event: o_mode = 1, o_pos = 0, o_six_dp = 6'b000011. Two pos events: o_pos = 2, o_six_dp = 6'b110000. A third pos event: o_pos = 0.
- In SET with hour selected: 24 inc events give o_hour sequence 1..23, 0, with min and sec unchanged. Ticks during SET leave o_sec unchanged.
- Simultaneous events:
  - mode and inc edges in the same clk: only o_mode toggles.
  - pos and inc in SET on SEC: sec+1, then o_pos = 1.
  - tick and a CLOCK -> SET mode edge at sec = 5: o_sec = 6, o_mode = 1.
- Button held high for 1000 clks gives one increment. Asserting rst mid-SET at 12:34:56 asynchronously returns all outputs to 0 before the next clk edge. HOUR_MAX = 11 build: 11:59:59 plus a tick gives 0:00:00.
